id_operand_stage: RTL and testbench
===================================

// Module: id_operand_stage
// PURPOSE
//  Parametrised decode-stage operand unit for the pipelined MIPS core: register file, per-register
//  pending-write scoreboard, write-through/forward operand resolution, stall generation and the
//  valid/ready ID->EX pipeline register. Sits between fetch/decode control and EX; WB drives its write port.
// PARAMETERS
//  XLEN     32  datapath width
//  NREGS    32  architectural registers; RA_W = $clog2(NREGS); register 0 reads 0, never written or tracked
//  NFWD     3   forwarding sources; index 0 = youngest (EX), NFWD-1 = oldest
//  SB_W     2   scoreboard counter width; max in-flight writes per register = 2**SB_W-1
// PORTS
//  clk        in   1            clock, rising edge
//  reset      in   1            asynchronous, active-low (0 = reset)
//  d_valid    in   1            decoded instruction present
//  d_ready    out  1            instruction accepted this cycle (0 = stall fetch/decode)
//  d_rs_addr  in   RA_W         source A;  d_rs_used in 1: A needed
//  d_rt_addr  in   RA_W         source B;  d_rt_used in 1: B needed
//  d_wr_en    in   1            instruction writes a register; d_wr_addr in RA_W destination
//  d_imm16    in   16           immediate; d_ext_sign in 1: 1 sign-extend, 0 zero-extend
//  d_pc4      in   XLEN         PC+4 of instruction
//  fwd_valid  in   NFWD         source k holds an in-flight write
//  fwd_ready  in   NFWD         source k result available now
//  fwd_addr   in   NFWD*RA_W    destination of source k
//  fwd_data   in   NFWD*XLEN    result of source k
//  w_en       in   1            WB write; w_addr in RA_W; w_data in XLEN
//  flush      in   1            kill decode instruction and EX register content
//  e_ready    in   1            EX accepts
//  e_valid    out  1            EX register holds an instruction
//  e_rs_data, e_rt_data, e_ext, e_pc8  out XLEN   resolved operands, extended imm, PC+8
//  e_wr_en    out  1; e_wr_addr out RA_W          destination passed down
// BEHAVIOUR
//  Reset: all registers 0, all counters 0, e_valid=0, every e_* output 0.
//  Operand resolve (per used source r != 0), first match wins:
//   1) count[r]==0 -> regfile (write-through: w_en & w_addr==r gives w_data).
//   2) lowest k with fwd_valid[k] & fwd_addr[k]==r: ready -> fwd_data[k]; not ready -> stall.
//   3) w_en & w_addr==r & count[r]==1 -> w_data.  4) otherwise stall.
//   r==0 or source unused -> 0, never stalls.
//  Stall also when d_wr_en & d_wr_addr!=0 & count[d_wr_addr] saturated.
//  d_ready = operands resolved & !saturated & !flush & (!e_valid | e_ready).
//  Issue (d_valid & d_ready): EX register loads next edge (latency 1); e_pc8=d_pc4+4; count[d_wr_addr]+1.
//  e_ready & no issue -> e_valid=0 (bubble). !e_ready -> EX register holds, all e_* stable.
//  Scoreboard: -1 on w_en & w_addr!=0. Issue and retire same reg same cycle -> unchanged.
//   Retire on a zero count is ignored (no wrap).
//  Flush: no issue that cycle; e_valid=0 next edge; if e_valid & e_wr_en, count[e_wr_addr]-1
//   (combined with WB retire in same cycle: -2, floor 0). Younger stages flush themselves.
//  WB write to r0 discarded. Reset mid-operation clears all state asynchronously.
// STRUCTURE
//  Shared package: XLEN/RA_W defaults, fwd source index constants, sign/zero ext helper function.
//  One sub-module: id_scoreboard (NREGS counters, inc/dec/flush-dec ports, busy and saturated outputs).
//  Regfile, resolve muxes, EX register stay in this module.
// TESTING
//  1) Reset low mid-run -> e_valid=0, reads of r5 return 0, count[5]=0 after release.
//  2) Issue write r8; next instr reads r8, fwd0 valid, not ready -> d_ready=0; fwd_ready=1, data
//     0xDEADBEEF -> e_rs_data=0xDEADBEEF one cycle later.
//  3) w_en r3=0x1234 same cycle as read of r3 (count 1, no fwd match) -> e_rt_data=0x1234, count 0.
//  4) Three issues to r9 (SB_W=2) -> 4th write-r9 stalls; one WB retire -> accepted next cycle.
//  5) e_ready=0 for 3 cycles -> e_* stable, d_ready=0; flush with e_wr_addr=4 -> e_valid=0, count[4]-1.
//  6) d_imm16=0x8000: d_ext_sign=1 -> e_ext=0xFFFF8000; 0 -> 0x00008000; w_en to r0 -> r0 reads 0.

Source files
------------

// File: rtl/id_operand_stage_pkg.sv
// id_operand_stage_pkg: shared widths, forwarding source indices and immediate extension helper.
package id_operand_stage_pkg;
    localparam int XLEN    = 32;
    localparam int NREGS   = 32;
    localparam int RA_W    = $clog2(NREGS);
    localparam int NFWD    = 3;
    localparam int SB_W    = 2;
    localparam int FWD_EX  = 0;
    localparam int FWD_MEM = 1;
    localparam int FWD_WB  = NFWD - 1;

    // Wide result so any XLEN up to 64 can truncate it.
    function automatic logic [63:0] ext16(input logic [15:0] imm, input logic sgn);
        return {{48{sgn & imm[15]}}, imm};
    endfunction
endpackage

// File: rtl/id_operand_stage_if.sv
// id_operand_stage_if: decode, forwarding, writeback and EX-side signals of the operand stage.
interface id_operand_stage_if #(
    parameter int XLEN  = id_operand_stage_pkg::XLEN,
    parameter int NREGS = id_operand_stage_pkg::NREGS,
    parameter int NFWD  = id_operand_stage_pkg::NFWD
);
    localparam int RA_W = $clog2(NREGS);
    logic                 d_valid, d_ready, d_rs_used, d_rt_used, d_wr_en, d_ext_sign;
    logic [RA_W-1:0]      d_rs_addr, d_rt_addr, d_wr_addr;
    logic [15:0]          d_imm16;
    logic [XLEN-1:0]      d_pc4;
    logic [NFWD-1:0]      fwd_valid, fwd_ready;
    logic [NFWD*RA_W-1:0] fwd_addr;
    logic [NFWD*XLEN-1:0] fwd_data;
    logic                 w_en;
    logic [RA_W-1:0]      w_addr;
    logic [XLEN-1:0]      w_data;
    logic                 flush, e_ready, e_valid, e_wr_en;
    logic [XLEN-1:0]      e_rs_data, e_rt_data, e_ext, e_pc8;
    logic [RA_W-1:0]      e_wr_addr;

    modport master (
        output d_valid, d_rs_addr, d_rs_used, d_rt_addr, d_rt_used, d_wr_en, d_wr_addr,
               d_imm16, d_ext_sign, d_pc4, fwd_valid, fwd_ready, fwd_addr, fwd_data,
               w_en, w_addr, w_data, flush, e_ready,
        input  d_ready, e_valid, e_rs_data, e_rt_data, e_ext, e_pc8, e_wr_en, e_wr_addr
    );
    modport slave (
        input  d_valid, d_rs_addr, d_rs_used, d_rt_addr, d_rt_used, d_wr_en, d_wr_addr,
               d_imm16, d_ext_sign, d_pc4, fwd_valid, fwd_ready, fwd_addr, fwd_data,
               w_en, w_addr, w_data, flush, e_ready,
        output d_ready, e_valid, e_rs_data, e_rt_data, e_ext, e_pc8, e_wr_en, e_wr_addr
    );
endinterface

// File: rtl/id_scoreboard.sv
// id_scoreboard: per-register in-flight write counters; r0 is never tracked, counts floor at 0.
module id_scoreboard #(
    parameter int NREGS = id_operand_stage_pkg::NREGS,
    parameter int SB_W  = id_operand_stage_pkg::SB_W
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        inc_en,
    input  logic [$clog2(NREGS)-1:0]    inc_addr,
    input  logic                        dec_en,
    input  logic [$clog2(NREGS)-1:0]    dec_addr,
    input  logic                        fdec_en,
    input  logic [$clog2(NREGS)-1:0]    fdec_addr,
    output logic [NREGS-1:0][SB_W-1:0]  cnt,
    output logic [NREGS-1:0]            busy,
    output logic [NREGS-1:0]            sat
);
    localparam int RA_W = $clog2(NREGS);
    logic [NREGS-1:0][SB_W-1:0] nxt;
    logic [SB_W:0]              up, dn;

    always_comb begin
        nxt = '0;
        up  = '0;
        dn  = '0;
        for (int i = 1; i < NREGS; i++) begin
            up     = {1'b0, cnt[i]} + (SB_W+1)'(inc_en && inc_addr == RA_W'(i));
            dn     = (SB_W+1)'(dec_en && dec_addr == RA_W'(i)) + (SB_W+1)'(fdec_en && fdec_addr == RA_W'(i));
            nxt[i] = up > dn ? SB_W'(up - dn) : '0;
        end
    end

    always_ff @(posedge clk or negedge reset)
        if (!reset) cnt <= '0;
        else        cnt <= nxt;

    for (genvar g = 0; g < NREGS; g++) begin : g_flag
        assign busy[g] = cnt[g] != '0;
        assign sat[g]  = &cnt[g];
    end
endmodule

// File: rtl/id_operand_stage.sv
// id_operand_stage: register file, pending-write scoreboard, operand forwarding/stall and ID->EX register.
module id_operand_stage #(
    parameter int XLEN  = id_operand_stage_pkg::XLEN,
    parameter int NREGS = id_operand_stage_pkg::NREGS,
    parameter int NFWD  = id_operand_stage_pkg::NFWD,
    parameter int SB_W  = id_operand_stage_pkg::SB_W
) (
    input logic                clk,
    input logic                reset,
    id_operand_stage_if.slave  bus
);
    import id_operand_stage_pkg::*;
    localparam int RA_W = $clog2(NREGS);

    logic [XLEN-1:0]            rf [NREGS];
    logic [NREGS-1:0][SB_W-1:0] cnt;
    logic [NREGS-1:0]           busy, sat;
    logic [RA_W-1:0]            src_addr [2];
    logic [1:0]                 src_used, src_ok;
    logic [XLEN-1:0]            src_data [2];
    logic                       full, issue;

    assign src_addr[0] = bus.d_rs_addr;
    assign src_addr[1] = bus.d_rt_addr;
    assign src_used    = {bus.d_rt_used, bus.d_rs_used};

    for (genvar s = 0; s < 2; s++) begin : g_src
        logic            hit, hrdy, wb, zero;
        logic [XLEN-1:0] hdat;
        // Scan oldest to youngest so the youngest matching source overrides.
        always_comb begin
            hit  = 1'b0;
            hrdy = 1'b0;
            hdat = '0;
            for (int k = NFWD - 1; k >= 0; k--)
                if (bus.fwd_valid[k] && bus.fwd_addr[k*RA_W +: RA_W] == src_addr[s]) begin
                    hit  = 1'b1;
                    hrdy = bus.fwd_ready[k];
                    hdat = bus.fwd_data[k*XLEN +: XLEN];
                end
        end
        assign zero = !src_used[s] || src_addr[s] == '0;
        assign wb   = bus.w_en && bus.w_addr == src_addr[s];
        assign src_ok[s] = zero || !busy[src_addr[s]] ||
                           (hit ? hrdy : wb && cnt[src_addr[s]] == SB_W'(1));
        assign src_data[s] = zero                   ? '0 :
                             !busy[src_addr[s]]     ? (wb ? bus.w_data : rf[src_addr[s]]) :
                             hit                    ? hdat :
                             wb                     ? bus.w_data : '0;
    end

    assign full        = bus.d_wr_en && bus.d_wr_addr != '0 && sat[bus.d_wr_addr];
    assign bus.d_ready = &src_ok && !full && !bus.flush && (!bus.e_valid || bus.e_ready);
    assign issue       = bus.d_valid && bus.d_ready;

    always_ff @(posedge clk or negedge reset)
        if (!reset) for (int i = 0; i < NREGS; i++) rf[i] <= '0;
        else if (bus.w_en && bus.w_addr != '0) rf[bus.w_addr] <= bus.w_data;

    always_ff @(posedge clk or negedge reset)
        if (!reset) begin
            bus.e_valid   <= 1'b0;
            bus.e_rs_data <= '0;
            bus.e_rt_data <= '0;
            bus.e_ext     <= '0;
            bus.e_pc8     <= '0;
            bus.e_wr_en   <= 1'b0;
            bus.e_wr_addr <= '0;
        end else if (bus.flush) begin
            bus.e_valid <= 1'b0;
        end else if (issue) begin
            bus.e_valid   <= 1'b1;
            bus.e_rs_data <= src_data[0];
            bus.e_rt_data <= src_data[1];
            bus.e_ext     <= XLEN'(ext16(bus.d_imm16, bus.d_ext_sign));
            bus.e_pc8     <= bus.d_pc4 + XLEN'(4);
            bus.e_wr_en   <= bus.d_wr_en;
            bus.e_wr_addr <= bus.d_wr_addr;
        end else if (bus.e_ready) begin
            bus.e_valid <= 1'b0;
        end

    id_scoreboard #(.NREGS(NREGS), .SB_W(SB_W)) u_sb (
        .clk       (clk),
        .reset     (reset),
        .inc_en    (issue && bus.d_wr_en),
        .inc_addr  (bus.d_wr_addr),
        .dec_en    (bus.w_en),
        .dec_addr  (bus.w_addr),
        .fdec_en   (bus.flush && bus.e_valid && bus.e_wr_en),
        .fdec_addr (bus.e_wr_addr),
        .cnt       (cnt),
        .busy      (busy),
        .sat       (sat)
    );
endmodule

// File: tb/tb_id_operand_stage.sv
// tb_id_operand_stage: scenario tasks with a queue of expected EX-register contents.
module tb_id_operand_stage;
    typedef struct packed {
        logic [31:0] rs, rt, ext, pc8;
        logic        we;
        logic [4:0]  wa;
    } ex_t;

    logic clk, reset;
    int   n_cmp = 0, n_bad = 0;
    ex_t  q[$];

    id_operand_stage_if #(.XLEN(32), .NREGS(32), .NFWD(3)) bus ();
    id_operand_stage #(.XLEN(32), .NREGS(32), .NFWD(3), .SB_W(2)) dut (.clk(clk), .reset(reset), .bus(bus));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, want finish before 200000");
        $fatal(1);
    end

    function automatic ex_t mk(logic [31:0] rs, logic [31:0] rt, logic [31:0] ext, logic [31:0] pc8, logic we, logic [4:0] wa);
        return '{rs, rt, ext, pc8, we, wa};
    endfunction

    function automatic ex_t cur();
        return '{bus.e_rs_data, bus.e_rt_data, bus.e_ext, bus.e_pc8, bus.e_wr_en, bus.e_wr_addr};
    endfunction

    function automatic string fmt(ex_t x);
        return $sformatf("rs=%h rt=%h ext=%h pc8=%h we=%b wa=%0d", x.rs, x.rt, x.ext, x.pc8, x.we, x.wa);
    endfunction

    task automatic clear_in();
        bus.d_valid = 0; bus.d_rs_addr = 0; bus.d_rs_used = 0; bus.d_rt_addr = 0; bus.d_rt_used = 0;
        bus.d_wr_en = 0; bus.d_wr_addr = 0; bus.d_imm16 = 0; bus.d_ext_sign = 0; bus.d_pc4 = 0;
        bus.fwd_valid = 0; bus.fwd_ready = 0; bus.fwd_addr = 0; bus.fwd_data = 0;
        bus.w_en = 0; bus.w_addr = 0; bus.w_data = 0; bus.flush = 0; bus.e_ready = 1;
    endtask

    task automatic set_instr(input logic [4:0] rs, input logic rsu, input logic [4:0] rt, input logic rtu,
                             input logic we, input logic [4:0] wa, input logic [15:0] imm, input logic sg,
                             input logic [31:0] pc4);
        bus.d_rs_addr = rs; bus.d_rs_used = rsu; bus.d_rt_addr = rt; bus.d_rt_used = rtu;
        bus.d_wr_en = we; bus.d_wr_addr = wa; bus.d_imm16 = imm; bus.d_ext_sign = sg; bus.d_pc4 = pc4;
    endtask

    // Holds d_valid until the stage accepts (bounded); returns at the cycle after the issuing edge.
    task automatic issue(input logic [4:0] rs, input logic rsu, input logic [4:0] rt, input logic rtu,
                         input logic we, input logic [4:0] wa, input logic [15:0] imm, input logic sg,
                         input logic [31:0] pc4, output bit took);
        set_instr(rs, rsu, rt, rtu, we, wa, imm, sg, pc4);
        bus.d_valid = 1;
        took = 0;
        for (int i = 0; i < 8 && !took; i++) begin
            @(negedge clk);
            if (bus.d_ready) took = 1;
            @(posedge clk); #1;
        end
        bus.d_valid = 0;
    endtask

    task automatic take(output ex_t got, output ex_t exp, output bit have);
        got  = cur();
        have = bus.e_valid && q.size() > 0;
        exp  = '0;
        if (q.size() > 0) exp = q.pop_front();
    endtask

    task automatic test_reset();
        ex_t got, exp; bit took, have;
        clear_in();
        reset = 0;
        #12;
        n_cmp++;
        if (bus.e_valid !== 1'b0 || cur() !== '0) begin
            n_bad++; $display("FAIL reset_state: got v=%b %s, want v=0 all zero", bus.e_valid, fmt(cur()));
        end
        @(posedge clk); #1 reset = 1;
        bus.w_en = 1; bus.w_addr = 5; bus.w_data = 32'h55;
        @(posedge clk); #1 bus.w_en = 0;
        q.push_back(mk(0, 0, 0, 32'h104, 1, 5));
        issue(0, 0, 0, 0, 1, 5, 0, 0, 32'h100, took);
        take(got, exp, have);
        n_cmp++;
        if (!took || !have || got !== exp || dut.u_sb.cnt[5] !== 2'd1) begin
            n_bad++; $display("FAIL reset_pre_ex: got %s cnt=%0d, want %s cnt=1", fmt(got), dut.u_sb.cnt[5], fmt(exp));
        end
        #2 reset = 0;
        #1;
        n_cmp++;
        if (bus.e_valid !== 1'b0 || dut.u_sb.cnt[5] !== 2'd0) begin
            n_bad++; $display("FAIL reset_async: got v=%b cnt5=%0d, want v=0 cnt5=0", bus.e_valid, dut.u_sb.cnt[5]);
        end
        #2 reset = 1;
        q.push_back(mk(0, 0, 0, 32'h204, 0, 0));
        issue(5, 1, 0, 0, 0, 0, 0, 0, 32'h200, took);
        take(got, exp, have);
        n_cmp++;
        if (!took || !have || got !== exp || dut.u_sb.cnt[5] !== 2'd0) begin
            n_bad++; $display("FAIL reset_read_r5: got %s cnt=%0d, want %s cnt=0", fmt(got), dut.u_sb.cnt[5], fmt(exp));
        end
    endtask

    task automatic test_forward();
        ex_t got, exp; bit took, have;
        clear_in();
        q.push_back(mk(0, 0, 0, 32'h304, 1, 8));
        issue(0, 0, 0, 0, 1, 8, 0, 0, 32'h300, took);
        take(got, exp, have);
        n_cmp++;
        if (!took || !have || got !== exp) begin
            n_bad++; $display("FAIL fwd_producer: got %s, want %s", fmt(got), fmt(exp));
        end
        set_instr(8, 1, 0, 0, 0, 0, 0, 0, 32'h310);
        bus.d_valid = 1;
        bus.fwd_valid = 3'b011; bus.fwd_ready = 3'b010;
        bus.fwd_addr = {5'd0, 5'd8, 5'd8};
        bus.fwd_data = {32'h0, 32'h0BAD0BAD, 32'h0};
        @(negedge clk);
        n_cmp++;
        if (bus.d_ready !== 1'b0) begin
            n_bad++; $display("FAIL fwd_stall: got d_ready=%b, want 0", bus.d_ready);
        end
        @(posedge clk); #1;
        bus.fwd_ready = 3'b011;
        bus.fwd_data = {32'h0, 32'h0BAD0BAD, 32'hDEADBEEF};
        @(negedge clk);
        n_cmp++;
        if (bus.d_ready !== 1'b1) begin
            n_bad++; $display("FAIL fwd_release: got d_ready=%b, want 1", bus.d_ready);
        end
        q.push_back(mk(32'hDEADBEEF, 0, 0, 32'h314, 0, 0));
        @(posedge clk); #1;
        bus.d_valid = 0; bus.fwd_valid = 0; bus.fwd_ready = 0;
        take(got, exp, have);
        n_cmp++;
        if (!have || got !== exp) begin
            n_bad++; $display("FAIL fwd_data: got %s, want %s", fmt(got), fmt(exp));
        end
        bus.w_en = 1; bus.w_addr = 8; bus.w_data = 32'hDEADBEEF;
        @(posedge clk); #1 bus.w_en = 0;
        n_cmp++;
        if (dut.u_sb.cnt[8] !== 2'd0) begin
            n_bad++; $display("FAIL fwd_retire: got cnt8=%0d, want 0", dut.u_sb.cnt[8]);
        end
    endtask

    task automatic test_wb_bypass();
        ex_t got, exp; bit took, have;
        clear_in();
        q.push_back(mk(0, 0, 0, 32'h404, 1, 3));
        issue(0, 0, 0, 0, 1, 3, 0, 0, 32'h400, took);
        take(got, exp, have);
        n_cmp++;
        if (!took || !have || got !== exp) begin
            n_bad++; $display("FAIL wb_producer: got %s, want %s", fmt(got), fmt(exp));
        end
        set_instr(0, 0, 3, 1, 0, 0, 0, 0, 32'h410);
        bus.d_valid = 1; bus.w_en = 1; bus.w_addr = 3; bus.w_data = 32'h1234;
        @(negedge clk);
        n_cmp++;
        if (bus.d_ready !== 1'b1) begin
            n_bad++; $display("FAIL wb_ready: got d_ready=%b, want 1", bus.d_ready);
        end
        q.push_back(mk(0, 32'h1234, 0, 32'h414, 0, 0));
        @(posedge clk); #1;
        bus.d_valid = 0; bus.w_en = 0;
        take(got, exp, have);
        n_cmp++;
        if (!have || got !== exp || dut.u_sb.cnt[3] !== 2'd0) begin
            n_bad++; $display("FAIL wb_bypass: got %s cnt3=%0d, want %s cnt3=0", fmt(got), dut.u_sb.cnt[3], fmt(exp));
        end
    endtask

    task automatic test_saturate();
        ex_t got, exp; bit took, have;
        clear_in();
        for (int i = 0; i < 3; i++) begin
            q.push_back(mk(0, 0, 0, 32'h504 + 32'(i * 4), 1, 9));
            issue(0, 0, 0, 0, 1, 9, 0, 0, 32'h500 + 32'(i * 4), took);
            take(got, exp, have);
            n_cmp++;
            if (!took || !have || got !== exp) begin
                n_bad++; $display("FAIL sat_issue%0d: got %s, want %s", i, fmt(got), fmt(exp));
            end
        end
        set_instr(0, 0, 0, 0, 1, 9, 0, 0, 32'h50C);
        bus.d_valid = 1;
        @(negedge clk);
        n_cmp++;
        if (bus.d_ready !== 1'b0 || dut.u_sb.cnt[9] !== 2'd3) begin
            n_bad++; $display("FAIL sat_stall: got d_ready=%b cnt9=%0d, want 0 3", bus.d_ready, dut.u_sb.cnt[9]);
        end
        @(posedge clk); #1;
        bus.w_en = 1; bus.w_addr = 9; bus.w_data = 0;
        @(negedge clk);
        n_cmp++;
        if (bus.d_ready !== 1'b0) begin
            n_bad++; $display("FAIL sat_retire_cycle: got d_ready=%b, want 0", bus.d_ready);
        end
        @(posedge clk); #1 bus.w_en = 0;
        @(negedge clk);
        n_cmp++;
        if (bus.d_ready !== 1'b1) begin
            n_bad++; $display("FAIL sat_accept: got d_ready=%b, want 1", bus.d_ready);
        end
        q.push_back(mk(0, 0, 0, 32'h510, 1, 9));
        @(posedge clk); #1 bus.d_valid = 0;
        take(got, exp, have);
        n_cmp++;
        if (!have || got !== exp || dut.u_sb.cnt[9] !== 2'd3) begin
            n_bad++; $display("FAIL sat_fourth: got %s cnt9=%0d, want %s cnt9=3", fmt(got), dut.u_sb.cnt[9], fmt(exp));
        end
        bus.w_en = 1; bus.w_addr = 9;
        repeat (3) @(posedge clk);
        #1 bus.w_en = 0;
        @(posedge clk); #1;
        n_cmp++;
        if (dut.u_sb.cnt[9] !== 2'd0) begin
            n_bad++; $display("FAIL sat_floor: got cnt9=%0d, want 0", dut.u_sb.cnt[9]);
        end
    endtask

    task automatic test_hold_flush();
        ex_t got, exp, snap; bit took, have;
        clear_in();
        q.push_back(mk(0, 0, 32'h42, 32'h604, 1, 4));
        issue(0, 0, 0, 0, 1, 4, 16'h0042, 0, 32'h600, took);
        take(got, exp, have);
        n_cmp++;
        if (!took || !have || got !== exp) begin
            n_bad++; $display("FAIL hold_load: got %s, want %s", fmt(got), fmt(exp));
        end
        snap = exp;
        bus.e_ready = 0;
        set_instr(0, 0, 0, 0, 0, 0, 0, 0, 32'h700);
        bus.d_valid = 1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            n_cmp++;
            if (bus.d_ready !== 1'b0 || bus.e_valid !== 1'b1 || cur() !== snap) begin
                n_bad++; $display("FAIL hold_cycle%0d: got r=%b v=%b %s, want r=0 v=1 %s", i, bus.d_ready, bus.e_valid, fmt(cur()), fmt(snap));
            end
            @(posedge clk); #1;
        end
        bus.flush = 1;
        @(posedge clk); #1;
        bus.flush = 0; bus.d_valid = 0;
        n_cmp++;
        if (bus.e_valid !== 1'b0 || dut.u_sb.cnt[4] !== 2'd0) begin
            n_bad++; $display("FAIL flush_ex: got v=%b cnt4=%0d, want v=0 cnt4=0", bus.e_valid, dut.u_sb.cnt[4]);
        end
        bus.e_ready = 1;
        for (int i = 0; i < 2; i++) begin
            q.push_back(mk(0, 0, 0, 32'h804 + 32'(i * 4), 1, 6));
            issue(0, 0, 0, 0, 1, 6, 0, 0, 32'h800 + 32'(i * 4), took);
            take(got, exp, have);
            n_cmp++;
            if (!took || !have || got !== exp) begin
                n_bad++; $display("FAIL flush2_issue%0d: got %s, want %s", i, fmt(got), fmt(exp));
            end
        end
        bus.e_ready = 0;
        bus.flush = 1; bus.w_en = 1; bus.w_addr = 6; bus.w_data = 0;
        @(posedge clk); #1;
        bus.flush = 0; bus.w_en = 0; bus.e_ready = 1;
        n_cmp++;
        if (bus.e_valid !== 1'b0 || dut.u_sb.cnt[6] !== 2'd0) begin
            n_bad++; $display("FAIL flush_wb_combined: got v=%b cnt6=%0d, want v=0 cnt6=0", bus.e_valid, dut.u_sb.cnt[6]);
        end
    endtask

    task automatic test_ext_r0();
        ex_t got, exp; bit took, have;
        clear_in();
        q.push_back(mk(0, 0, 32'hFFFF8000, 32'h904, 0, 0));
        issue(0, 0, 0, 0, 0, 0, 16'h8000, 1, 32'h900, took);
        take(got, exp, have);
        n_cmp++;
        if (!took || !have || got !== exp) begin
            n_bad++; $display("FAIL ext_sign: got %s, want %s", fmt(got), fmt(exp));
        end
        q.push_back(mk(0, 0, 32'h00008000, 32'h914, 0, 0));
        issue(0, 0, 0, 0, 0, 0, 16'h8000, 0, 32'h910, took);
        take(got, exp, have);
        n_cmp++;
        if (!took || !have || got !== exp) begin
            n_bad++; $display("FAIL ext_zero: got %s, want %s", fmt(got), fmt(exp));
        end
        bus.w_en = 1; bus.w_addr = 0; bus.w_data = 32'hFFFFFFFF;
        @(posedge clk); #1 bus.w_en = 0;
        q.push_back(mk(0, 32'h1234, 0, 32'h924, 0, 0));
        issue(0, 1, 3, 1, 0, 0, 0, 0, 32'h920, took);
        take(got, exp, have);
        n_cmp++;
        if (!took || !have || got !== exp) begin
            n_bad++; $display("FAIL r0_read: got %s, want %s", fmt(got), fmt(exp));
        end
        q.push_back(mk(0, 0, 0, 32'h934, 0, 0));
        issue(3, 0, 3, 0, 0, 0, 0, 0, 32'h930, took);
        take(got, exp, have);
        n_cmp++;
        if (!took || !have || got !== exp) begin
            n_bad++; $display("FAIL unused_src: got %s, want %s", fmt(got), fmt(exp));
        end
    endtask

    initial begin
        test_reset();
        test_forward();
        test_wb_bypass();
        test_saturate();
        test_hold_flush();
        test_ext_r0();
        n_cmp++;
        if (q.size() != 0) begin
            n_bad++; $display("FAIL queue_drain: got %0d left, want 0", q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
